// File: rtl/sound_pkg.sv
// Shared types and constants for the sound sequencer: melody and state
// encodings, note frequency codes, melody lengths and the pending-slot merge.
// Hop support is compiled in only when SOUND_HOP_EN is defined.
package sound_pkg;

    typedef enum logic [1:0] {MEL_NONE, MEL_LOSE, MEL_WIN, MEL_HOP} melody_e;
    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} sound_state_e;

    localparam int NOTE_W = 10;
    localparam logic [NOTE_W-1:0] NOTE_C4  = 10'd262;
    localparam logic [NOTE_W-1:0] NOTE_E4  = 10'd330;
    localparam logic [NOTE_W-1:0] NOTE_G4  = 10'd392;
    localparam logic [NOTE_W-1:0] NOTE_C5  = 10'd523;
    localparam logic [NOTE_W-1:0] NOTE_HOP = 10'd660;

    localparam int LOSE_LEN = 3;
    localparam int WIN_LEN  = 4;
    localparam int HOP_LEN  = 1;

    // A lose always wins the slot; a win only fills a slot not holding a lose.
    function automatic melody_e slot_merge(input melody_e cur, input logic lose, input logic win);
        if (lose) return MEL_LOSE;
        if (win && cur != MEL_LOSE) return MEL_WIN;
        return cur;
    endfunction

endpackage

// File: rtl/sound_melody_rom.sv
// Melody ROM: maps (melody, note index) to the note's frequency code plus
// last-note and short-note flags. The HOP entry exists only with SOUND_HOP_EN.
module sound_melody_rom
    import sound_pkg::*;
#(
    parameter int FREQ_W = 10
) (
    input  melody_e           melody,
    input  logic [1:0]        idx,
    output logic [FREQ_W-1:0] freq,
    output logic              last,
    output logic              short_note
);

    logic [NOTE_W-1:0] code;
    int                len;

    // Table lookup; unknown melodies read as silence with no last flag.
    always_comb begin
        code       = '0;
        len        = 0;
        short_note = 1'b0;
        case (melody)
            MEL_LOSE: begin
                len = LOSE_LEN;
                case (idx)
                    2'd0:    code = NOTE_G4;
                    2'd1:    code = NOTE_E4;
                    default: code = NOTE_C4;
                endcase
            end
            MEL_WIN: begin
                len = WIN_LEN;
                case (idx)
                    2'd0:    code = NOTE_C4;
                    2'd1:    code = NOTE_E4;
                    2'd2:    code = NOTE_G4;
                    default: code = NOTE_C5;
                endcase
            end
`ifdef SOUND_HOP_EN
            MEL_HOP: begin
                len        = HOP_LEN;
                code       = NOTE_HOP;
                short_note = 1'b1;
            end
`endif
            default: begin
                len  = 0;
                code = '0;
            end
        endcase
        freq = FREQ_W'(code);
        last = (len != 0) && (int'(idx) == len - 1);
    end

endmodule

// File: rtl/sound_sequencer.sv
// Sound sequencer: arbitrates lose/win/hop requests and plays the chosen
// melody note by note with fixed note and gap durations. One pending slot
// holds a win/lose request that arrives while a melody is in progress.
// Optional hop support: define SOUND_HOP_EN.
//
//   state | meaning
//   IDLE  | silent, waiting for a request
//   PLAY  | tone on, current note held for its duration
//   GAP   | tone off between notes of one melody
//   DONE  | one-cycle completion pulse, then pending melody or IDLE
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int FREQ_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lose_req,
    input  logic              win_req,
    input  logic              hop_req,
    output logic [FREQ_W-1:0] sound_freq_out,
    output logic              enable_sound,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(NOTE_TICKS + 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(NOTE_TICKS - 1);
    localparam logic [CW-1:0] SHORT_LOAD = CW'(NOTE_TICKS / 4 - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_TICKS - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_GAP  = GAP;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state, state_n;
    melody_e           mel, mel_n, pend, pend_n, req_mel, cand;
    logic [1:0]        idx, idx_n;
    logic [CW-1:0]     cnt;
    logic              last_q, note_start, gap_start;
    logic [FREQ_W-1:0] rom_freq;
    logic              rom_last, rom_short;

    assign cand = slot_merge(pend, lose_req, win_req);

    // Highest-priority incoming request; hop participates only when enabled.
    always_comb begin
        req_mel = MEL_NONE;
        if (lose_req)     req_mel = MEL_LOSE;
        else if (win_req) req_mel = MEL_WIN;
`ifdef SOUND_HOP_EN
        else if (hop_req) req_mel = MEL_HOP;
`endif
    end

`ifndef SOUND_HOP_EN
    logic unused_hop;
    assign unused_hop = hop_req;
`endif

    // ROM is addressed with the next melody/note so outputs can be registered.
    sound_melody_rom #(.FREQ_W(FREQ_W)) u_rom (
        .melody     (mel_n),
        .idx        (idx_n),
        .freq       (rom_freq),
        .last       (rom_last),
        .short_note (rom_short)
    );

    // Next-state, melody selection and pending-slot update.
    always_comb begin
        state_n    = state;
        mel_n      = mel;
        idx_n      = idx;
        pend_n     = pend;
        note_start = 1'b0;
        gap_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_mel != MEL_NONE) begin
                    state_n    = ST_PLAY;
                    mel_n      = req_mel;
                    idx_n      = 2'd0;
                    note_start = 1'b1;
                    if (lose_req && win_req) pend_n = MEL_WIN;
                end
            end
            ST_PLAY, ST_GAP: begin
`ifdef SOUND_HOP_EN
                if (mel == MEL_HOP && (lose_req || win_req)) begin
                    state_n    = ST_PLAY;
                    mel_n      = req_mel;
                    idx_n      = 2'd0;
                    note_start = 1'b1;
                    if (lose_req && win_req) pend_n = MEL_WIN;
                end else
`endif
                begin
                    pend_n = cand;
                    if (cnt == '0) begin
                        if (state == ST_PLAY) begin
                            if (last_q) begin
                                state_n = ST_DONE;
                            end else begin
                                state_n   = ST_GAP;
                                gap_start = 1'b1;
                            end
                        end else begin
                            state_n    = ST_PLAY;
                            idx_n      = idx + 2'd1;
                            note_start = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                pend_n = MEL_NONE;
                if (cand != MEL_NONE) begin
                    state_n    = ST_PLAY;
                    mel_n      = cand;
                    idx_n      = 2'd0;
                    note_start = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    mel_n   = MEL_NONE;
                    idx_n   = 2'd0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                mel_n   = MEL_NONE;
            end
        endcase
    end

    // State, tick counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            mel            <= MEL_NONE;
            pend           <= MEL_NONE;
            idx            <= 2'd0;
            cnt            <= '0;
            last_q         <= 1'b0;
            sound_freq_out <= '0;
            enable_sound   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state <= state_n;
            mel   <= mel_n;
            pend  <= pend_n;
            idx   <= idx_n;
            if (note_start) begin
                cnt    <= rom_short ? SHORT_LOAD : LONG_LOAD;
                last_q <= rom_last;
            end else if (gap_start) begin
                cnt <= GAP_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            sound_freq_out <= (state_n == ST_PLAY) ? rom_freq : '0;
            enable_sound   <= (state_n == ST_PLAY);
            busy           <= (state_n == ST_PLAY) || (state_n == ST_GAP);
            done           <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with NOTE_TICKS = 8, GAP_TICKS = 2.
// Outputs are sampled 1 time unit after each rising edge; a request driven at
// a sample point is taken at the next edge.
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lose_req = 1'b0;
    logic       win_req = 1'b0;
    logic       hop_req = 1'b0;
    logic [9:0] sound_freq_out;
    logic       enable_sound;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sound_sequencer #(.NOTE_TICKS(8), .GAP_TICKS(2), .FREQ_W(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .lose_req       (lose_req),
        .win_req        (win_req),
        .hop_req        (hop_req),
        .sound_freq_out (sound_freq_out),
        .enable_sound   (enable_sound),
        .busy           (busy),
        .done           (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_silent(input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            check({tag, "_en"}, 32'(enable_sound), 0);
            check({tag, "_busy"}, 32'(busy), 0);
            check({tag, "_done"}, 32'(done), 0);
            step();
        end
    endtask

    // Called at the sample point of a melody's first note cycle; checks every
    // cycle through its done pulse, optionally pulsing lose/win at relative
    // cycles, and returns at the sample point of the cycle after done.
    task automatic expect_melody(input string tag, input int n,
                                 input logic [9:0] c0, input logic [9:0] c1,
                                 input logic [9:0] c2, input logic [9:0] c3,
                                 input int lose_at, input int win_at);
        logic [9:0] codes [4];
        int p;
        int nt;
        codes[0] = c0;
        codes[1] = c1;
        codes[2] = c2;
        codes[3] = c3;
        for (int k = 1; k <= n * 10 - 1; k++) begin
            p  = (k - 1) % 10;
            nt = (k - 1) / 10;
            if (k == n * 10 - 1) begin
                check({tag, "_done"}, 32'(done), 1);
                check({tag, "_en_at_done"}, 32'(enable_sound), 0);
                check({tag, "_busy_at_done"}, 32'(busy), 0);
            end else begin
                check({tag, "_done_low"}, 32'(done), 0);
                check({tag, "_busy"}, 32'(busy), 1);
                check({tag, "_en"}, 32'(enable_sound), (p < 8) ? 1 : 0);
                if (p < 8) check({tag, "_freq"}, 32'(sound_freq_out), 32'(codes[nt]));
            end
            lose_req = (k == lose_at);
            win_req  = (k == win_at);
            step();
            lose_req = 1'b0;
            win_req  = 1'b0;
        end
    endtask

    initial begin
        #1;
        // Reset held three cycles: every output low.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_en", 32'(enable_sound), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_freq", 32'(sound_freq_out), 0);
        end
        reset = 1'b0;
        check_silent("idle", 10);

        // Plain win melody.
        win_req = 1'b1;
        step();
        win_req = 1'b0;
        expect_melody("win", 4, 10'd262, 10'd330, 10'd392, 10'd523, 0, 0);
        check_silent("after_win", 4);

        // Lose and win together: lose plays, win follows from the slot.
        lose_req = 1'b1;
        win_req  = 1'b1;
        step();
        lose_req = 1'b0;
        win_req  = 1'b0;
        expect_melody("lose_first", 3, 10'd392, 10'd330, 10'd262, 10'd0, 0, 0);
        expect_melody("win_pending", 4, 10'd262, 10'd330, 10'd392, 10'd523, 0, 0);
        check_silent("after_pair", 4);

        // Lose arrives during win (pending), later win is dropped; no preemption.
        win_req = 1'b1;
        step();
        win_req = 1'b0;
        expect_melody("win_busy", 4, 10'd262, 10'd330, 10'd392, 10'd523, 3, 5);
        expect_melody("lose_chain", 3, 10'd392, 10'd330, 10'd262, 10'd0, 0, 0);
        check_silent("after_chain", 12);

        // Reset mid-win with a lose pending: silence next cycle, lose never plays.
        win_req = 1'b1;
        step();
        win_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check("rst_mid_en", 32'(enable_sound), 1);
            check("rst_mid_freq", 32'(sound_freq_out), 262);
            if (c == 2) lose_req = 1'b1;
            if (c == 5) reset = 1'b1;
            step();
            lose_req = 1'b0;
        end
        reset = 1'b0;
        check_silent("post_reset", 40);

`ifdef SOUND_HOP_EN
        // Hop alone: short note, then done.
        hop_req = 1'b1;
        step();
        hop_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check("hop_en", 32'(enable_sound), 1);
            check("hop_freq", 32'(sound_freq_out), 660);
            check("hop_done_low", 32'(done), 0);
            step();
        end
        check("hop_done", 32'(done), 1);
        check("hop_en_off", 32'(enable_sound), 0);
        step();
        check_silent("after_hop", 3);

        // Hop preempted by lose one cycle later.
        hop_req = 1'b1;
        step();
        hop_req = 1'b0;
        check("preempt_hop_en", 32'(enable_sound), 1);
        check("preempt_hop_freq", 32'(sound_freq_out), 660);
        lose_req = 1'b1;
        step();
        lose_req = 1'b0;
        expect_melody("preempt_lose", 3, 10'd392, 10'd330, 10'd262, 10'd0, 0, 0);
        check_silent("after_preempt", 4);
`else
        // Hop ignored when hop support is not built in.
        hop_req = 1'b1;
        step();
        hop_req = 1'b0;
        check_silent("hop_ignored", 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Plays the game's sound effects: arbitrates one-cycle sound requests from game control (lose, win, frog hop) and sequences the chosen melody, note by note, onto the shared tone generator. It sits between the game FSM and the tone/audio block. It drives the frequency code and enable that the game FSM previously drove directly, with fixed durations and gaps. Notes come from a small melody ROM.

## Interface
Parameters:
- NOTE_TICKS, default 12_500_000: cycles a full note is held (250 ms at 50 MHz). Must be ≥ 4.
- GAP_TICKS, default 2_500_000: silent cycles between consecutive notes of one melody. Must be ≥ 1.
- FREQ_W, default 10: width of the frequency code.

Ports:
- clk, in, 1: system clock. One clock domain.
- reset, in, 1: synchronous, active-high reset.
- lose_req, in, 1: one-cycle pulse requesting the lose melody.
- win_req, in, 1: one-cycle pulse requesting the win melody.
- hop_req, in, 1: one-cycle pulse requesting the hop chirp.
- sound_freq_out, out, FREQ_W: frequency code for the tone generator. Valid while enable_sound = 1.
- enable_sound, out, 1: tone generator on.
- busy, out, 1: a melody is in progress (PLAY or GAP).
- done, out, 1: one-cycle pulse when a melody completes normally.

## Operation
- States are IDLE, PLAY, GAP and DONE. All outputs are registered.
- Melodies and their frequency codes:
  - LOSE: 392, 330, 262.
  - WIN: 262, 330, 392, 523.
  - HOP: 660, one note held NOTE_TICKS/4 cycles.
- Priority is LOSE > WIN > HOP.
- IDLE with a request: go to PLAY at note 0 of the highest-priority request.
  - If lose and win arrive together, LOSE plays and WIN goes to the pending slot.
- PLAY:
  - enable_sound = 1 and sound_freq_out = current note.
  - The tick counter counts down from the note length minus 1.
  - When it expires: if this is the last note, go to DONE; otherwise go to GAP.
- GAP:
  - enable_sound = 0.
  - After GAP_TICKS cycles, go to PLAY at the next note.
- DONE:
  - done = 1, busy = 0, enable_sound = 0, lasting one cycle.
  - Then go to PLAY with the pending melody if the slot is full, otherwise to IDLE.
- Pending slot (one entry, holds win or lose only):
  - A win/lose request that arrives while busy, or during DONE, is stored in the slot.
  - LOSE overwrites a pending WIN. A WIN that arrives while LOSE is pending is dropped.
- Preemption:
  - A lose or win request during a HOP melody aborts the HOP. The next cycle is PLAY at note 0 of the new melody.
  - An aborted melody produces no done pulse.
  - A hop_req while busy or during DONE is dropped.
  - A win/lose request never preempts a win/lose melody already playing.
- Widths:
  - Tick counter width is $clog2(NOTE_TICKS+1).
  - Note index is 2 bits.
  - The frequency code is zero-extended to FREQ_W.

## Timing
- Reset value of every output is 0. State returns to IDLE and the pending slot is cleared.
- A reset mid-melody forces silence in the cycle after reset is sampled.
- Latency from request to sound: a request sampled in cycle N gives enable_sound = 1 with note 0 in cycle N+1.
- Each note holds enable_sound high for exactly NOTE_TICKS consecutive cycles (NOTE_TICKS/4 for HOP).
- Each gap holds enable_sound low for exactly GAP_TICKS cycles.
- done asserts in the cycle after the last note's final cycle.
- A pending melody starts one cycle after DONE.
- busy is 1 in PLAY and GAP and 0 in IDLE and DONE.

## Configuration
- Macro SOUND_HOP_EN.
- When defined: the hop requester is active and the ROM contains the HOP entry.
- When undefined: the hop_req port remains but is ignored, the ROM has no HOP entry, and there is no hop arbitration logic. Win/lose behaviour is unchanged.

## Structure
- Shared package sound_pkg contains:
  - melody_e {MEL_NONE, MEL_LOSE, MEL_WIN, MEL_HOP};
  - sound_state_e {IDLE, PLAY, GAP, DONE};
  - the note-code localparams;
  - melody lengths.
- Sub-module sound_melody_rom: combinational lookup from (melody_e, note index) to {freq code, last-note flag, short-note flag}.

## Test plan
All scenarios use NOTE_TICKS = 8 and GAP_TICKS = 2.
1. Reset: hold reset for 3 cycles → all outputs 0, and nothing plays for 10 idle cycles.
2. win_req at cycle 0 → freq 262 in cycles 1–8, 330 in 11–18, 392 in 21–28, 523 in 31–38. Silent gaps at 9–10, 19–20 and 29–30. done = 1 at cycle 39.
3. lose_req and win_req together at cycle 0 → LOSE (392, 330, 262) with done at cycle 29. WIN's 262 starts at cycle 30.
4. hop_req at cycle 0, then lose_req at cycle 1 → 660 only in cycle 1, 392 from cycle 2, and no done pulse for the hop.
5. reset asserted at cycle 5 of a WIN with LOSE pending → silence from cycle 6 and the pending LOSE is never played.
6. SOUND_HOP_EN undefined, hop_req pulsed → enable_sound, busy and done stay 0.
